dac_sample_arbiter: RTL and testbench
=====================================

Name: dac_sample_arbiter

Overview:
- Shares the single 10-bit DAC code input between two requesters: the core's output word (port 0) and an auxiliary source (port 1).
- Paces DAC updates to a programmable sample tick derived from the PLL clock.
- Grants round-robin and holds each code for a settle window before the next update.
- Sits between the core, the auxiliary source and the DAC's D input; the SoC top instantiates it.

Parameters:
- DIV, 16, clock cycles per sample tick (legal ≥ 2).
- SETTLE_CYC, 4, cycles DAC_BUSY stays high after each update (0 = no settle state).
- RESET_CODE, 10'd512, DAC code driven out of reset (midscale).

Ports:
- CLK  input  1  PLL clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- valid0  input  1  port-0 sample request.
- data0  input  10  port-0 sample code.
- ready0  output  1  port-0 accept.
- valid1  input  1  port-1 sample request.
- data1  input  10  port-1 sample code.
- ready1  output  1  port-1 accept.
- D  output  10  registered code to DAC.
- DAC_BUSY  output  1  high during settle window.
- last_src  output  1  source of the current D (0/1).
- overrun  output  8  saturating count of ticks lost while a tick was already pending.

Behaviour:
- Reset is synchronous and active-high on CLK. All state clears on the edge where reset=1:
  - D=RESET_CODE, DAC_BUSY=0, last_src=0, overrun=0.
  - tick counter=0, tick_pending=0, state=IDLE, rr_last=1 (so port 0 wins the first tie).
  - Reset mid-SETTLE aborts to IDLE. Reset in the handshake cycle discards the sample; that handshake does not complete.
- Tick counter:
  - Counts 0..DIV-1 and wraps to 0. tick=1 when count==DIV-1.
  - On tick: if tick_pending=0, set it; if already 1, overrun++ (saturates at 255).
- FSM states: IDLE, SETTLE.
  - IDLE: when tick_pending=1 and (valid0|valid1), grant one port.
    - Only valid0 → port 0; only valid1 → port 1.
    - Both valid → port != rr_last.
  - ready_g is combinational and asserted only in that cycle; the non-granted ready stays 0.
  - On the clock edge:
    - D<=data_g, last_src<=g, rr_last<=g, tick_pending<=0.
    - If SETTLE_CYC>0: go to SETTLE with settle count=SETTLE_CYC-1 and DAC_BUSY<=1. Otherwise stay in IDLE.
  - Latency: D reflects the accepted data on the edge ending the handshake cycle, 1 cycle after the grant decision.
  - Tick and grant in the same cycle: tick_pending stays 1 (the new tick re-arms it); no overrun.
  - SETTLE: ready0=ready1=0 and the settle count decrements. At 0: DAC_BUSY<=0, return to IDLE. Ticks arriving during SETTLE follow the normal pending/overrun rule.
- No request pending: D holds its last value indefinitely. tick_pending stays set and later ticks count as overrun.
- Requesters must hold valid and data stable until ready. Dropping valid before ready is legal: no handshake occurs and nothing is latched.

Optional Feature:
- Macro DAC_RAMP_TEST_EN.
- Defined:
  - Adds input test_en (1 bit).
  - While test_en=1: ready0=ready1=0. Each tick, in IDLE, loads D<=D+1 (1023 wraps to 0) and goes through SETTLE as usual. last_src=0; rr_last unchanged.
  - test_en deassert returns to normal arbitration at the next tick.
- Undefined: the test_en port and the ramp logic are absent.

Test Plan:
- Reset: assert reset 2 cycles → D=512, DAC_BUSY=0, overrun=0, ready0=ready1=0.
- Single source: DIV=16, SETTLE_CYC=4, valid0=1, data0=10'h155 held → ready0 pulses 1 cycle after the first tick; D=0x155 next edge; DAC_BUSY high 4 cycles; last_src=0.
- Contention: valid0=valid1=1 held, data0=100, data1=900 → D sequence 100, 900, 100, 900 on successive ticks; exactly one ready per tick.
- Overrun: no valid for 5 ticks after reset → overrun=4 (first tick arms pending); then valid1 → accepted within 1 cycle; overrun stays 4.
- Reset mid-SETTLE: reset during cycle 2 of settle → DAC_BUSY=0, D=512, next grant needs a fresh tick.
- Ramp (DAC_RAMP_TEST_EN): D=1022, test_en=1 → D=1023, 0, 1 on successive ticks; ready0/ready1 stay 0 even with valid0=1.

Source files
------------

// File: rtl/dac_sample_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dac_sample_arbiter                                            |
// | Purpose  : Shares the 10-bit DAC code input between two requesters.      |
// |            Updates are paced by a programmable sample tick. Ports are    |
// |            granted round-robin. Each code is held for a settle window.   |
// | Ports    : CLK, reset        - PLL clock, synchronous active-high reset   |
// |            valid0/data0/ready0 - port 0 (core output word)               |
// |            valid1/data1/ready1 - port 1 (auxiliary source)               |
// |            D                - registered code to the DAC                 |
// |            DAC_BUSY         - high during the settle window              |
// |            last_src         - source of the current D                    |
// |            overrun          - saturating count of lost ticks             |
// |            test_en          - ramp test enable (DAC_RAMP_TEST_EN only)   |
// | Options  : `define DAC_RAMP_TEST_EN adds the test_en port and the        |
// |            ramp generator.                                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dac_sample_arbiter #(
  parameter int         DIV        = 16,
  parameter int         SETTLE_CYC = 4,
  parameter logic [9:0] RESET_CODE = 10'd512
) (
  input  logic       CLK,
  input  logic       reset,
`ifdef DAC_RAMP_TEST_EN
  input  logic       test_en,
`endif
  input  logic       valid0,
  input  logic [9:0] data0,
  output logic       ready0,
  input  logic       valid1,
  input  logic [9:0] data1,
  output logic       ready1,
  output logic [9:0] D,
  output logic       DAC_BUSY,
  output logic       last_src,
  output logic [7:0] overrun
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_SETTLE = 1'b1;

  localparam logic [CW-1:0] TICK_LAST  = CW'(DIV - 1);
  localparam logic [SW-1:0] SETTLE_TOP = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [7:0]    over_q, over_d;
  logic [0:0]    state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [9:0]    code_q, code_d;
  logic          busy_q, busy_d;
  logic          last_q, last_d;
  logic          rr_q, rr_d;

  logic tick;
  logic gsel;
  logic can_fire;
  logic hs;
  logic ramp;
  logic load;
  logic test_mode;

`ifdef DAC_RAMP_TEST_EN
  assign test_mode = test_en;
`else
  assign test_mode = 1'b0;
`endif

  always_comb begin
    tick     = (cnt_q == TICK_LAST);
    // With both requesting, the port that did not win last time goes next.
    gsel     = (valid0 & valid1) ? ~rr_q : valid1;
    // A sample in the reset cycle is discarded, so no ready is shown then.
    can_fire = (state_q == S_IDLE) & pend_q & ~reset;
    hs       = can_fire & ~test_mode & (valid0 | valid1);
    ramp     = can_fire & test_mode;
    load     = hs | ramp;
    ready0   = hs & ~gsel;
    ready1   = hs & gsel;
  end

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    pend_d   = pend_q;
    over_d   = over_q;
    state_d  = state_q;
    settle_d = settle_q;
    code_d   = code_q;
    busy_d   = busy_q;
    last_d   = last_q;
    rr_d     = rr_q;

    // Consuming the pending tick and a new tick in the same cycle re-arms
    // the pending flag instead of counting an overrun.
    if (load) begin
      pend_d = tick;
    end else if (tick) begin
      if (pend_q) begin
        over_d = (over_q == 8'hFF) ? over_q : over_q + 8'd1;
      end else begin
        pend_d = 1'b1;
      end
    end

    if (load) begin
      if (ramp) begin
        code_d = code_q + 10'd1;
        last_d = 1'b0;
      end else begin
        code_d = gsel ? data1 : data0;
        last_d = gsel;
        rr_d   = gsel;
      end
      if (SETTLE_CYC > 0) begin
        state_d  = S_SETTLE;
        settle_d = SETTLE_TOP;
        busy_d   = 1'b1;
      end
    end else if (state_q == S_SETTLE) begin
      if (settle_q == '0) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        settle_d = settle_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      over_q   <= 8'd0;
      state_q  <= S_IDLE;
      settle_q <= '0;
      code_q   <= RESET_CODE;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
      rr_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      over_q   <= over_d;
      state_q  <= state_d;
      settle_q <= settle_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      rr_q     <= rr_d;
    end
  end

  assign D        = code_q;
  assign DAC_BUSY = busy_q;
  assign last_src = last_q;
  assign overrun  = over_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dac_sample_arbiter                                         |
// | Purpose  : Scoreboard bench for dac_sample_arbiter with a tick/settle    |
// |            reference model and randomized requesters.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dac_sample_arbiter;

  localparam int         DIV    = 16;
  localparam int         SETTLE = 4;
  localparam logic [9:0] RCODE  = 10'd512;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic [9:0] data0 = '0, data1 = '0;
  logic       ready0, ready1, DAC_BUSY, last_src;
  logic [9:0] D;
  logic [7:0] overrun;
`ifdef DAC_RAMP_TEST_EN
  logic       test_en = 1'b0;
`endif

  dac_sample_arbiter #(.DIV(DIV), .SETTLE_CYC(SETTLE), .RESET_CODE(RCODE)) dut (
    .CLK      (CLK),
    .reset    (reset),
`ifdef DAC_RAMP_TEST_EN
    .test_en  (test_en),
`endif
    .valid0   (valid0),
    .data0    (data0),
    .ready0   (ready0),
    .valid1   (valid1),
    .data1    (data1),
    .ready1   (ready1),
    .D        (D),
    .DAC_BUSY (DAC_BUSY),
    .last_src (last_src),
    .overrun  (overrun)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct { int cyc; bit port; } gnt_t;
  typedef struct { logic [9:0] d; bit busy; bit last; int over; } st_t;
  gnt_t gq[$];
  st_t  sq[$];

  // Reference model: cycles since reset, pending flag, remaining busy cycles.
  int         m_phase, m_busy, m_over;
  bit         m_pend, m_last, m_rr;
  logic [9:0] m_D;

  int checks = 0, failures = 0;
  bit mon_en = 1'b1;

  bit         req0, req1, g, gp;
  logic [9:0] dat0, dat1;

  task automatic model_reset();
    m_phase = 0; m_busy = 0; m_over = 0;
    m_pend = 0; m_last = 0; m_rr = 1; m_D = RCODE;
  endtask

  task automatic step(input bit r);
    bit tk;
    @(posedge CLK); #1;
    reset = r; valid0 = req0; data0 = dat0; valid1 = req1; data1 = dat1;
    g = 0; gp = 0;
    if (r) begin
      model_reset();
    end else begin
      tk = ((m_phase % DIV) == DIV - 1);
      m_phase++;
      if (m_busy == 0 && m_pend && (req0 || req1)) begin
        g  = 1;
        gp = (req0 && req1) ? !m_rr : req1;
        m_D = gp ? dat1 : dat0;
        m_last = gp; m_rr = gp; m_busy = SETTLE;
        m_pend = tk;
        gq.push_back('{cyc, gp});
      end else begin
        if (m_busy > 0) m_busy--;
        if (tk) begin
          if (m_pend) m_over = (m_over < 255) ? m_over + 1 : 255;
          else m_pend = 1;
        end
      end
    end
    sq.push_back('{m_D, (m_busy > 0), m_last, m_over});
  endtask

  // Monitor: compares the DUT against the scoreboard queues each cycle.
  always @(negedge CLK) begin
    st_t  s;
    gnt_t e;
    bit   have;
    if (mon_en) begin
      if (sq.size() == 0) begin
        checks++; failures++;
        $display("FAIL state_queue cyc=%0d got=empty required=entry", cyc);
      end else begin
        s = sq.pop_front();
        checks++;
        if (D !== s.d) begin failures++; $display("FAIL D cyc=%0d got=%0d required=%0d", cyc, D, s.d); end
        checks++;
        if (DAC_BUSY !== s.busy) begin failures++; $display("FAIL busy cyc=%0d got=%0b required=%0b", cyc, DAC_BUSY, s.busy); end
        checks++;
        if (last_src !== s.last) begin failures++; $display("FAIL last_src cyc=%0d got=%0b required=%0b", cyc, last_src, s.last); end
        checks++;
        if (int'(overrun) != s.over || $isunknown(overrun)) begin
          failures++; $display("FAIL overrun cyc=%0d got=%0d required=%0d", cyc, overrun, s.over);
        end
      end
      have = (gq.size() > 0) && (gq[0].cyc == cyc);
      if (ready0 === 1'b1 || ready1 === 1'b1 || have) begin
        checks++;
        if (ready0 === 1'b1 && ready1 === 1'b1) begin
          failures++; $display("FAIL ready_both cyc=%0d got=11 required=one", cyc);
          if (have) void'(gq.pop_front());
        end else if (!have) begin
          failures++; $display("FAIL ready_unexpected cyc=%0d got=%0b%0b required=00", cyc, ready1, ready0);
        end else begin
          e = gq.pop_front();
          if (!(ready0 === 1'b1 || ready1 === 1'b1)) begin
            failures++; $display("FAIL ready_missing cyc=%0d got=00 required_port=%0d", cyc, e.port);
          end else if ((ready1 === 1'b1) != e.port) begin
            failures++; $display("FAIL grant_port cyc=%0d got=%0b required=%0b", cyc, ready1, e.port);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    sq.push_back('{m_D, 1'b0, 1'b0, 0});
    req0 = 0; req1 = 0; dat0 = '0; dat1 = '0;
    step(1);

    // Idle ticks: first tick arms pending, the next four are overruns.
    repeat (5 * DIV) step(0);

    // Single requester on port 1 after the overrun phase.
    req1 = 1; dat1 = 10'($urandom); g = 0;
    for (int i = 0; i < 4 * DIV && !g; i++) step(0);
    req1 = 0;
    repeat (3 * DIV) step(0);

    // Contention with held requests: must alternate.
    req0 = 1; dat0 = 10'd100; req1 = 1; dat1 = 10'd900;
    repeat (6 * DIV) step(0);
    req0 = 0; req1 = 0;
    repeat (DIV) step(0);

    // Reset during the second settle cycle.
    req0 = 1; dat0 = 10'h155; g = 0;
    for (int i = 0; i < 3 * DIV && !g; i++) step(0);
    req0 = 0;
    step(0);
    step(1);
    repeat (3 * DIV) step(0);

    // Long idle to reach overrun saturation.
    repeat (262 * DIV) step(0);

    // Randomized requesters with occasional resets.
    repeat (3000) begin
      if (!req0 && $urandom_range(3) == 0) begin req0 = 1; dat0 = 10'($urandom); end
      else if (req0 && $urandom_range(63) == 0) req0 = 0;
      if (!req1 && $urandom_range(3) == 0) begin req1 = 1; dat1 = 10'($urandom); end
      else if (req1 && $urandom_range(63) == 0) req1 = 0;
      step($urandom_range(499) == 0);
      if (g) begin
        if (gp) req1 = 0; else req0 = 0;
      end
    end

    req0 = 0; req1 = 0;
    step(0);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    mon_en = 0;
    checks++;
    if (gq.size() != 0) begin
      failures++; $display("FAIL grants_left got=%0d required=0", gq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
